// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch flushes and
// multi-cycle MUL/DIV occupancy of EX, plus stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  input  logic        rs1Used_id,
  input  logic        rs2Used_id,
  input  logic        JumpTaken_ex,
  input  logic        MulDiv_ex,
  output logic        PC_IFWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        MD_start,
  output logic        MD_done,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam int unsigned CntW = $clog2(MD_LAT);

  typedef enum logic {StRun, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [31:0]     flush_cnt_q, flush_cnt_d;
  logic            lu;
  logic            jump_flush;

  assign lu = MemRead_ex && (rdAddr_ex != 5'd0) &&
              ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
               (rs2Used_id && (rs2Addr_id == rdAddr_ex)));

  always_comb begin
    PC_IFWrite   = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MD_start     = 1'b0;
    MD_done      = 1'b0;
    jump_flush   = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (!rst_n) begin
      // Hold every stage in bubbles while reset is asserted.
      PC_IFWrite   = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (MulDiv_ex) begin
            MD_start     = 1'b1;
            PC_IFWrite   = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            state_d      = StBusy;
            cnt_d        = CntW'(MD_LAT - 2);
          end else if (JumpTaken_ex) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            jump_flush  = 1'b1;
          end else if (lu) begin
            PC_IFWrite  = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            PC_IFWrite   = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            cnt_d        = cnt_q - CntW'(1);
          end else begin
            MD_done = 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign stall_cnt_d = stall_cnt_q + {31'd0, ~PC_IFWrite};
  assign flush_cnt_d = flush_cnt_q + {31'd0, jump_flush};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MD_LAT = 4, 2, 8) share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_rd, rs1_used, rs2_used, jump, muldiv;
  logic [4:0] rd, rs1, rs2;

  logic [2:0]  pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f, md_start, md_done;
  logic [31:0] stall_cnt [3];
  logic [31:0] flush_cnt [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead_ex(mem_rd), .rdAddr_ex(rd),
    .rs1Addr_id(rs1), .rs2Addr_id(rs2), .rs1Used_id(rs1_used), .rs2Used_id(rs2_used),
    .JumpTaken_ex(jump), .MulDiv_ex(muldiv), .PC_IFWrite(pc_w[0]), .IF_ID_Write(ifid_w[0]),
    .ID_EX_Write(idex_w[0]), .IF_ID_Flush(ifid_f[0]), .ID_EX_Flush(idex_f[0]),
    .EX_MEM_Flush(exmem_f[0]), .MD_start(md_start[0]), .MD_done(md_done[0]),
    .StallCnt(stall_cnt[0]), .FlushCnt(flush_cnt[0])
  );

  hazard_ctrl #(.MD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .MemRead_ex(mem_rd), .rdAddr_ex(rd),
    .rs1Addr_id(rs1), .rs2Addr_id(rs2), .rs1Used_id(rs1_used), .rs2Used_id(rs2_used),
    .JumpTaken_ex(jump), .MulDiv_ex(muldiv), .PC_IFWrite(pc_w[1]), .IF_ID_Write(ifid_w[1]),
    .ID_EX_Write(idex_w[1]), .IF_ID_Flush(ifid_f[1]), .ID_EX_Flush(idex_f[1]),
    .EX_MEM_Flush(exmem_f[1]), .MD_start(md_start[1]), .MD_done(md_done[1]),
    .StallCnt(stall_cnt[1]), .FlushCnt(flush_cnt[1])
  );

  hazard_ctrl #(.MD_LAT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .MemRead_ex(mem_rd), .rdAddr_ex(rd),
    .rs1Addr_id(rs1), .rs2Addr_id(rs2), .rs1Used_id(rs1_used), .rs2Used_id(rs2_used),
    .JumpTaken_ex(jump), .MulDiv_ex(muldiv), .PC_IFWrite(pc_w[2]), .IF_ID_Write(ifid_w[2]),
    .ID_EX_Write(idex_w[2]), .IF_ID_Flush(ifid_f[2]), .ID_EX_Flush(idex_f[2]),
    .EX_MEM_Flush(exmem_f[2]), .MD_start(md_start[2]), .MD_done(md_done[2]),
    .StallCnt(stall_cnt[2]), .FlushCnt(flush_cnt[2])
  );

  // Control bits packed as {pc, ifid_w, idex_w, ifid_f, idex_f, exmem_f, start, done}
  localparam logic [7:0] CtlIdle   = 8'b111_000_00;
  localparam logic [7:0] CtlBubble = 8'b000_111_00;
  localparam logic [7:0] CtlLu     = 8'b001_010_00;
  localparam logic [7:0] CtlJump   = 8'b111_110_00;
  localparam logic [7:0] CtlMdT0   = 8'b000_001_10;
  localparam logic [7:0] CtlMdBusy = 8'b000_001_00;
  localparam logic [7:0] CtlMdDone = 8'b111_000_01;

  function automatic logic [7:0] ctl(input int k);
    return {pc_w[k], ifid_w[k], idex_w[k], ifid_f[k], idex_f[k], exmem_f[k],
            md_start[k], md_done[k]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    mem_rd = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0; jump = 1'b0; muldiv = 1'b0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  // Advance one clock, returning 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic saw_done;
    clr_in();
    rst_n = 1'b0;
    #1;
    check_eq("reset_bubble", {24'd0, ctl(0)}, {24'd0, CtlBubble});
    tick();
    tick();
    check_eq("reset_stallcnt", stall_cnt[0], 32'd0);
    check_eq("reset_flushcnt", flush_cnt[0], 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_default", {24'd0, ctl(0)}, {24'd0, CtlIdle});

    // Load-use on rs2
    mem_rd = 1'b1; rd = 5'd5; rs2_used = 1'b1; rs2 = 5'd5;
    #1;
    check_eq("lu_rs2", {24'd0, ctl(0)}, {24'd0, CtlLu});
    tick();
    clr_in();
    #1;
    check_eq("lu_one_cycle", {24'd0, ctl(0)}, {24'd0, CtlIdle});
    check_eq("lu_stallcnt", stall_cnt[0], 32'd1);

    // No stall: rd = x0, or source not used
    mem_rd = 1'b1; rd = 5'd0; rs2_used = 1'b1; rs2 = 5'd0;
    #1;
    check_eq("lu_rd_x0", {24'd0, ctl(0)}, {24'd0, CtlIdle});
    rd = 5'd5; rs2 = 5'd5; rs2_used = 1'b0;
    #1;
    check_eq("lu_rs2_unused", {24'd0, ctl(0)}, {24'd0, CtlIdle});
    mem_rd = 1'b0; rs2_used = 1'b1;
    #1;
    check_eq("lu_not_load", {24'd0, ctl(0)}, {24'd0, CtlIdle});
    tick();
    check_eq("nostall_cnt", stall_cnt[0], 32'd1);

    // Load-use on rs1
    clr_in();
    mem_rd = 1'b1; rd = 5'd7; rs1_used = 1'b1; rs1 = 5'd7;
    #1;
    check_eq("lu_rs1", {24'd0, ctl(0)}, {24'd0, CtlLu});
    tick();
    check_eq("lu_rs1_cnt", stall_cnt[0], 32'd2);

    // Taken branch overrides a simultaneous load-use
    clr_in();
    jump = 1'b1; mem_rd = 1'b1; rd = 5'd5; rs2_used = 1'b1; rs2 = 5'd5;
    #1;
    check_eq("jump_over_lu", {24'd0, ctl(0)}, {24'd0, CtlJump});
    tick();
    clr_in();
    #1;
    check_eq("jump_flushcnt", flush_cnt[0], 32'd1);
    check_eq("jump_stallcnt", stall_cnt[0], 32'd2);

    // MUL/DIV, MD_LAT = 4; jump at T1 must be ignored
    do_reset();
    muldiv = 1'b1;
    #1;
    check_eq("md4_t0", {24'd0, ctl(0)}, {24'd0, CtlMdT0});
    tick();
    muldiv = 1'b0; jump = 1'b1;
    #1;
    check_eq("md4_t1_jump_ignored", {24'd0, ctl(0)}, {24'd0, CtlMdBusy});
    tick();
    jump = 1'b0;
    #1;
    check_eq("md4_t2", {24'd0, ctl(0)}, {24'd0, CtlMdBusy});
    tick();
    check_eq("md4_t3_done", {24'd0, ctl(0)}, {24'd0, CtlMdDone});
    tick();
    check_eq("md4_back_run", {24'd0, ctl(0)}, {24'd0, CtlIdle});
    check_eq("md4_stallcnt", stall_cnt[0], 32'd3);
    check_eq("md4_flushcnt", flush_cnt[0], 32'd0);

    // MUL/DIV, MD_LAT = 2, back-to-back
    do_reset();
    muldiv = 1'b1;
    #1;
    check_eq("md2_t0", {24'd0, ctl(1)}, {24'd0, CtlMdT0});
    tick();
    muldiv = 1'b0;
    #1;
    check_eq("md2_t1_done", {24'd0, ctl(1)}, {24'd0, CtlMdDone});
    tick();
    muldiv = 1'b1;
    #1;
    check_eq("md2_t2_restart", {24'd0, ctl(1)}, {24'd0, CtlMdT0});
    tick();
    muldiv = 1'b0;
    #1;
    check_eq("md2_t3_done", {24'd0, ctl(1)}, {24'd0, CtlMdDone});
    tick();
    check_eq("md2_stallcnt", stall_cnt[1], 32'd2);

    // Reset mid-BUSY on MD_LAT = 8 aborts the op
    do_reset();
    muldiv = 1'b1;
    tick();
    muldiv = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("md8_reset_bubble", {24'd0, ctl(2)}, {24'd0, CtlBubble});
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("md8_after_reset", {24'd0, ctl(2)}, {24'd0, CtlIdle});
    check_eq("md8_reset_stallcnt", stall_cnt[2], 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (md_done[2] || !pc_w[2]) saw_done = 1'b1;
      tick();
    end
    check_eq("md8_no_done", {31'd0, saw_done}, 32'd0);

    // StallCnt wrap
    clr_in();
    force dut0.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut0.stall_cnt_q;
    #1;
    check_eq("wrap_preload", stall_cnt[0], 32'hFFFF_FFFF);
    mem_rd = 1'b1; rd = 5'd9; rs1_used = 1'b1; rs1 = 5'd9;
    tick();
    clr_in();
    #1;
    check_eq("wrap_stallcnt", stall_cnt[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core. It sits beside the ID/EX/MEM stages and sequences the EX datapath. It detects load-use hazards, flushes the wrong-path instructions after a taken branch or jump, and holds the pipeline while a multi-cycle MUL/DIV operation occupies EX. It also keeps stall and flush event counters for performance debug.

## Interface
- MD_LAT, 32: total EX occupancy in cycles of a multi-cycle MUL/DIV op. Legal range is MD_LAT ≥ 2.
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- MemRead_ex  in  1  instruction in EX is a load
- rdAddr_ex  in  5  destination register of the instruction in EX
- rs1Addr_id, rs2Addr_id  in  5 each  source registers of the instruction in ID
- rs1Used_id, rs2Used_id  in  1 each  the ID instruction actually reads rs1 / rs2
- JumpTaken_ex  in  1  branch or jump in EX resolved taken
- MulDiv_ex  in  1  instruction in EX is a multi-cycle MUL/DIV
- PC_IFWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Write  out  1  ID/EX register enable
- IF_ID_Flush  out  1  IF/ID register loads a NOP
- ID_EX_Flush  out  1  ID/EX register loads a bubble (all control bits 0)
- EX_MEM_Flush  out  1  EX/MEM register loads a bubble
- MD_start  out  1  one-cycle start pulse to the MUL/DIV unit
- MD_done  out  1  the EX result is valid this cycle (last occupancy cycle)
- StallCnt  out  32  count of stall cycles
- FlushCnt  out  32  count of taken-branch flush events

## Operation
- State machine with two states: RUN and BUSY. A down-counter cnt tracks progress, width ceil(log2(MD_LAT)).
- Default in RUN with no event: all write enables 1, all flushes 0, MD_start 0, MD_done 0.
- Load-use hazard. The condition is LU = MemRead_ex && rdAddr_ex != 0 && ((rs1Used_id && rs1Addr_id == rdAddr_ex) || (rs2Used_id && rs2Addr_id == rdAddr_ex)). When LU is true in RUN:
  - PC_IFWrite = 0 and IF_ID_Write = 0.
  - ID_EX_Flush = 1.
  - This is a one-cycle stall; forwarding from MEM resolves the hazard afterwards.
- Taken branch or jump (JumpTaken_ex in RUN):
  - IF_ID_Flush = 1 and ID_EX_Flush = 1.
  - PC_IFWrite = 1, so the PC loads the target.
  - LU is ignored in this cycle: the flush overrides the stall.
- Multi-cycle entry (MulDiv_ex in RUN), cycle T0:
  - MD_start = 1.
  - PC_IFWrite = IF_ID_Write = ID_EX_Write = 0.
  - EX_MEM_Flush = 1.
  - Next state is BUSY, with cnt loaded to MD_LAT-2.
  - MulDiv_ex has priority over both LU and JumpTaken_ex.
- In BUSY with cnt != 0: outputs are the same as at T0 except MD_start = 0, and cnt decrements.
- In BUSY with cnt == 0 (the done cycle):
  - MD_done = 1.
  - All write enables are 1 and all flushes are 0.
  - Next state is RUN.
  - Inputs LU, JumpTaken_ex and MulDiv_ex are ignored in BUSY.
- Counters:
  - StallCnt increments by 1 on every cycle in which PC_IFWrite = 0.
  - FlushCnt increments by 1 on every cycle in which JumpTaken_ex causes a flush.
  - Both counters wrap from 0xFFFFFFFF to 0.

## Timing
- All hazard outputs are combinational from the inputs plus the registered state. Zero latency: the stall or flush applies in the same cycle as the detected condition.
- A multi-cycle op occupies EX for exactly MD_LAT cycles (T0 to T0+MD_LAT-1) and stalls for MD_LAT-1 of them. MD_done is high only in cycle T0+MD_LAT-1.
- Reset: while rst_n = 0, the outputs are forced to hold the pipeline in bubbles:
  - PC_IFWrite = IF_ID_Write = ID_EX_Write = 0.
  - IF_ID_Flush = ID_EX_Flush = EX_MEM_Flush = 1.
  - MD_start = MD_done = 0.
- At the first clock edge with rst_n = 0: state becomes RUN, cnt = 0, StallCnt = FlushCnt = 0. Cycles spent in reset are not counted.
- Reset asserted mid-BUSY aborts the op: state returns to RUN next edge, and no MD_done is produced.
- Counter wrap and state transitions may occur in the same cycle without interaction.

## Test plan
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5 for one cycle -> PC_IFWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle only, and StallCnt goes 0→1. Repeat with rdAddr_ex=0 or rs2Used_id=0 -> no stall.
- Branch: JumpTaken_ex=1 at the same time as a load-use match -> IF_ID_Flush=1, ID_EX_Flush=1, PC_IFWrite=1, FlushCnt=1, StallCnt unchanged.
- MUL/DIV with MD_LAT=4: MulDiv_ex=1 at T0 ->
  - MD_start high at T0 only.
  - Stall and EX_MEM_Flush high at T0..T2.
  - MD_done=1 with enables=1 at T3, then back to RUN.
  - StallCnt=3.
  - JumpTaken_ex pulsed at T1 is ignored.
- MUL/DIV with MD_LAT=2: stall at T0 only, MD_done at T1. Back-to-back MulDiv_ex at T2 restarts cleanly with MD_start at T2.
- Reset mid-BUSY: rst_n=0 at T1 of an MD_LAT=8 op -> during reset the outputs show the bubble pattern; after release the state is RUN and no MD_done is produced.
- Wrap: preload StallCnt to 0xFFFFFFFF (force or long run), one stall cycle -> StallCnt=0.
